// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider for DIV/DIVU: one shift-and-subtract step per clock,
// followed by a sign fix-up cycle and a single-cycle done pulse.
module divider_32bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [32:0] part_rem;
    logic [31:0] dvd_mag;     // shifts out dividend bits, shifts in quotient bits
    logic [31:0] dsr_mag;
    logic [31:0] dvd_raw;
    logic [4:0]  count;
    logic        sgn_op, neg_dvd, neg_dsr, dsr_zero;
    logic [32:0] shifted, trial;

    always_comb begin
        shifted = {part_rem[31:0], dvd_mag[31]};
        trial   = shifted - {1'b0, dsr_mag};
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (count == 5'd31) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            part_rem    <= '0;
            dvd_mag     <= '0;
            dsr_mag     <= '0;
            dvd_raw     <= '0;
            count       <= '0;
            sgn_op      <= 1'b0;
            neg_dvd     <= 1'b0;
            neg_dsr     <= 1'b0;
            dsr_zero    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: if (start) begin
                    sgn_op   <= is_signed;
                    neg_dvd  <= is_signed & dividend[31];
                    neg_dsr  <= is_signed & divisor[31];
                    dsr_zero <= (divisor == 32'd0);
                    dvd_raw  <= dividend;
                    dvd_mag  <= (is_signed & dividend[31]) ? -dividend : dividend;
                    dsr_mag  <= (is_signed & divisor[31])  ? -divisor  : divisor;
                    part_rem <= '0;
                    count    <= '0;
                end
                RUN: begin
                    // trial[32] set means the subtraction went negative: restore
                    part_rem <= trial[32] ? shifted : trial;
                    dvd_mag  <= {dvd_mag[30:0], ~trial[32]};
                    count    <= count + 5'd1;
                end
                FIX: begin
                    div_by_zero <= dsr_zero;
                    if (dsr_zero) begin
                        quotient  <= 32'hFFFF_FFFF;
                        remainder <= dvd_raw;
                    end else begin
                        quotient  <= (sgn_op & (neg_dvd ^ neg_dsr)) ? -dvd_mag : dvd_mag;
                        remainder <= (sgn_op & neg_dvd) ? -part_rem[31:0] : part_rem[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: a driver pushes model results, a monitor
// pops and compares whenever done pulses.
module tb_divider_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    divider_32bit dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: truncating division in 64-bit arithmetic; sign of remainder follows dividend.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t   e;
        longint sa, sb_v, qq, rr;
        e.tag = tag;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a)); sb_v = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a}); sb_v = longint'({32'd0, b});
            end
            qq = sa / sb_v;
            rr = sa % sb_v;
            e.q = qq[31:0]; e.r = rr[31:0]; e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_quotient"},    quotient,    e.q);
                check({e.tag, "_remainder"},   remainder,   e.r);
                check({e.tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dz});
            end
        end
    end

    logic [31:0] last_q;

    // Issues one division; optionally injects an ignored start at cycle 10, or a reset at cycle 15.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit intrude, input bit abort);
        int cycles, busy_cnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        if (!abort) sb.push_back(model(s, a, b, tag));
        @(posedge clk);
        #1 start = 1'b0;
        dividend = $urandom; divisor = $urandom;
        cycles = 0; busy_cnt = 0; seen = 0;
        while (cycles < 100 && !seen) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
            if (done) seen = 1;
            if (intrude && cycles == 10) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
            end
            if (intrude && cycles == 11) start = 1'b0;
            if (cycles == 20) check({tag, "_hold_mid_run"}, quotient, last_q);
            if (abort && cycles == 15) begin
                reset = 1'b1;
                #1;
                check("reset_busy", {31'd0, busy}, 32'd0);
                check("reset_done", {31'd0, done}, 32'd0);
                check("reset_quotient", quotient, 32'd0);
                check("reset_remainder", remainder, 32'd0);
                check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
                last_q = 32'd0;
            end
        end
        if (abort) begin
            check("abort_no_done", {31'd0, seen}, 32'd0);
        end else begin
            check({tag, "_latency"}, cycles, 32'd34);
            check({tag, "_busy_cycles"}, busy_cnt, 32'd34);
            last_q = model(s, a, b, tag).q;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        last_q = 32'd0;
        repeat (2) @(negedge clk);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_quotient", quotient, 32'd0);
        check("init_remainder", remainder, 32'd0);
        check("init_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;

        issue(0, 32'd100, 32'd7, "divu_100_7", 0, 0);
        issue(1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0, 0);
        issue(1, 32'd7, 32'hFFFF_FFFE, "div_7_m2", 0, 0);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 0, 0);
        issue(0, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 0, 0);
        issue(1, 32'h1234_5678, 32'd0, "div_by0", 0, 0);
        issue(0, 32'h1234_5678, 32'd0, "divu_by0", 0, 0);
        issue(1, 32'hFFFF_FF00, 32'd0, "div_neg_by0", 0, 0);
        issue(0, 32'd100, 32'd7, "ignored_start", 1, 0);
        issue(0, 32'd9, 32'd3, "divu_9_3", 0, 0);
        issue(0, 32'd100, 32'd7, "aborted", 0, 1);
        issue(0, 32'd50, 32'd5, "divu_50_5", 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 15));
                1: b = -32'($urandom_range(1, 15));
                2: b = 32'd0;
                3: a = 32'h8000_0000;
                default: ;
            endcase
            issue(s, a, b, $sformatf("rand%0d", i), 0, 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
